// File: rtl/leading_one_pkg.sv
// Shared definitions for the leading-one detector/enumerator family: default
// sizes, the FSM state type, and small golden helpers for index legality and masks.
package leading_one_pkg;

    localparam int WIDTH_DEF = 9;
    localparam int IDX_W_DEF = 5;
    localparam int IDX_NONE  = -1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // An index is legal when it names a bit of the word, or IDX_NONE for the zero word.
    function automatic logic index_legal(input int idx, input int width);
        return (idx >= IDX_NONE) && (idx < width);
    endfunction

    // Largest word whose leading one sits at position k (all ones up to bit k).
    function automatic int end_mask(input int k);
        if (k < 0)
            return 0;
        return (1 << (k + 1)) - 1;
    endfunction

endpackage

// File: rtl/leading_one_enum.sv
// Enumerates, one word per output handshake, every WIDTH-bit value whose leading
// one sits at the requested signed index; index -1 yields the single word 0.
module leading_one_enum
    import leading_one_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IDX_W-1:0] in_index,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic        [WIDTH-1:0] out_data,
    output logic                    out_last,
    output logic                    busy,
    output logic                    err
);

    state_t             state;
    state_t             state_n;
    logic [WIDTH-1:0]   mask;
    logic [WIDTH-1:0]   mask_n;
    logic [WIDTH-1:0]   data_n;
    logic [WIDTH-1:0]   data_inc;
    logic [WIDTH-1:0]   one_hot;
    logic               valid_n;
    logic               last_n;
    logic               err_n;
    logic               legal;
    logic               accept;
    logic               transfer;
    int                 idx;

    assign in_ready = (state == IDLE);
    assign busy     = (state == RUN);
    assign accept   = in_valid && in_ready;
    assign transfer = out_valid && out_ready;

    // Sign-extend before the range check so an out-of-range index is never
    // truncated into a legal one.
    assign idx      = int'(in_index);
    assign legal    = index_legal(idx, WIDTH);
    assign one_hot  = {{(WIDTH-1){1'b0}}, 1'b1} << idx;
    assign data_inc = out_data + {{(WIDTH-1){1'b0}}, 1'b1};

    always_comb begin
        state_n = state;
        data_n  = out_data;
        last_n  = out_last;
        valid_n = out_valid;
        mask_n  = mask;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!legal) begin
                        err_n = 1'b1;
                    end else if (idx == IDX_NONE) begin
                        state_n = RUN;
                        valid_n = 1'b1;
                        data_n  = '0;
                        mask_n  = '0;
                        last_n  = 1'b1;
                    end else begin
                        state_n = RUN;
                        valid_n = 1'b1;
                        data_n  = one_hot;
                        mask_n  = one_hot | (one_hot - {{(WIDTH-1){1'b0}}, 1'b1});
                        last_n  = (idx == 0);
                    end
                end
            end
            RUN: begin
                // Termination compares against the end mask, so the
                // incrementer never needs to wrap.
                if (transfer) begin
                    if (out_last) begin
                        state_n = IDLE;
                        valid_n = 1'b0;
                        last_n  = 1'b0;
                    end else begin
                        data_n = data_inc;
                        last_n = (data_inc == mask);
                    end
                end
            end
            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
                last_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
            mask      <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            out_data  <= data_n;
            out_last  <= last_n;
            out_valid <= valid_n;
            mask      <= mask_n;
            err       <= err_n;
        end
    end

endmodule

// File: tb/tb_leading_one_enum.sv
// Directed self-checking bench for leading_one_enum: reset, enumerations with and
// without stalls, illegal indices, reset mid-run, and leading-one loopback.
module tb_leading_one_enum;

    localparam int WIDTH = 9;
    localparam int IDX_W = 5;

    logic                    clk;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [IDX_W-1:0] in_index;
    logic                    out_valid;
    logic                    out_ready;
    logic        [WIDTH-1:0] out_data;
    logic                    out_last;
    logic                    busy;
    logic                    err;

    int checks = 0;
    int errors = 0;

    leading_one_enum #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_index  (in_index),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent leading-one detector used for loopback checks.
    function automatic int leadingOne(input logic [WIDTH-1:0] d);
        int pos = -1;
        for (int i = 0; i < WIDTH; i++)
            if (d[i]) pos = i;
        return pos;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input int idx);
        in_valid = v;
        in_index = idx[IDX_W-1:0];
    endtask

    // Issues one request from IDLE and consumes the whole enumeration.
    task automatic runEnum(input int idx, input bit randomStall, input string tag);
        int count  = (idx < 0) ? 1 : (1 << idx);
        int base   = (idx < 0) ? 0 : (1 << idx);
        int beat   = 0;
        int cycles = 0;
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        applyStimulus(1'b1, idx);
        @(negedge clk);
        applyStimulus(1'b0, 0);
        while (beat < count && cycles < 4 * count + 50) begin
            checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
            checkOutput({tag, "_data"}, 32'(out_data), 32'(base + beat));
            checkOutput({tag, "_last"}, 32'(out_last), 32'(beat == count - 1));
            checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
            checkOutput({tag, "_loopback"}, 32'(leadingOne(out_data)), 32'(idx));
            out_ready = randomStall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_ready) beat++;
            cycles++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        checkOutput({tag, "_beats"}, 32'(beat), 32'(count));
        checkOutput({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_idle_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic runIllegal(input int idx, input string tag);
        applyStimulus(1'b1, idx);
        @(negedge clk);
        applyStimulus(1'b0, 0);
        checkOutput({tag, "_err"}, 32'(err), 32'd1);
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        checkOutput({tag, "_err_drop"}, 32'(err), 32'd0);
        checkOutput({tag, "_valid2"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b0;
        applyStimulus(1'b0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_data", 32'(out_data), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_err", 32'(err), 32'd0);

        runEnum(3, 1'b0, "idx3");
        runEnum(-1, 1'b0, "idxm1");
        runEnum(8, 1'b1, "idx8");

        runIllegal(9, "ill9");
        runIllegal(15, "ill15");
        runIllegal(-2, "illm2");

        // Abort an index-5 enumeration after beats 32..35.
        applyStimulus(1'b1, 5);
        @(negedge clk);
        applyStimulus(1'b0, 0);
        out_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            checkOutput("abort_data", 32'(out_data), 32'(32 + b));
            @(negedge clk);
        end
        checkOutput("abort_pre_data", 32'(out_data), 32'd36);
        out_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_valid", 32'(out_valid), 32'd0);
        checkOutput("abort_last", 32'(out_last), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
        runEnum(0, 1'b0, "idx0");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
